// File: rtl/coherence_bus_arbiter.sv
// Two-requester coherence bus arbiter: round-robin grant, broadcast command, peer snoop, response.
// Optional SNOOP-phase timeout is built in when SNOOP_TIMEOUT_EN is defined.
module coherence_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ooo_req,
  input  logic         ppl_req,
  input  logic [31:0]  ooo_addr,
  input  logic [31:0]  ppl_addr,
  input  logic [2:0]   ooo_cmd,
  input  logic [2:0]   ppl_cmd,
  input  logic [255:0] ooo_data,
  input  logic [255:0] ppl_data,
  input  logic         ooo_snoop_valid,
  input  logic         ppl_snoop_valid,
  input  logic         ooo_snoop_hit,
  input  logic         ppl_snoop_hit,
  input  logic [255:0] ooo_snoop_data,
  input  logic [255:0] ppl_snoop_data,
  output logic         bus_cmd_valid,
  output logic [31:0]  bus_cmd_addr,
  output logic [2:0]   bus_cmd_cmd,
  output logic [255:0] bus_cmd_data,
  output logic         bus_cmd_src,
  output logic         ooo_gnt,
  output logic         ppl_gnt,
  output logic         ooo_done,
  output logic         ppl_done,
  output logic [1:0]   resp_code,
  output logic [255:0] resp_data,
  output logic         bus_ready
);

  typedef enum logic [1:0] {IDLE, CMD, SNOOP, RESP} state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e         state_q;
  logic           last_src_q;
  logic           cmd_valid_q;
  logic [31:0]    addr_q;
  logic [2:0]     cmd_q;
  logic [255:0]   data_q;
  logic           src_q;
  logic           ooo_gnt_q;
  logic           ppl_gnt_q;
  logic           ooo_done_q;
  logic           ppl_done_q;
  logic [1:0]     resp_code_q;
  logic [255:0]   resp_data_q;
  logic           bus_ready_q;

`ifdef SNOOP_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  logic           win_ppl_d;
  logic [31:0]    addr_d;
  logic [2:0]     cmd_d;
  logic [255:0]   data_d;
  logic           peer_valid;
  logic           peer_hit;
  logic [255:0]   peer_data;

  // Contention goes to whoever was not served last; the peer is the non-owner cache.
  always_comb begin
    win_ppl_d  = ppl_req & (~ooo_req | ~last_src_q);
    addr_d     = win_ppl_d ? ppl_addr : ooo_addr;
    cmd_d      = win_ppl_d ? ppl_cmd  : ooo_cmd;
    data_d     = win_ppl_d ? ppl_data : ooo_data;
    peer_valid = src_q ? ooo_snoop_valid : ppl_snoop_valid;
    peer_hit   = src_q ? ooo_snoop_hit   : ppl_snoop_hit;
    peer_data  = src_q ? ooo_snoop_data  : ppl_snoop_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_src_q  <= 1'b1;
      cmd_valid_q <= 1'b0;
      addr_q      <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      src_q       <= 1'b0;
      ooo_gnt_q   <= 1'b0;
      ppl_gnt_q   <= 1'b0;
      ooo_done_q  <= 1'b0;
      ppl_done_q  <= 1'b0;
      resp_code_q <= '0;
      resp_data_q <= '0;
      bus_ready_q <= 1'b1;
`ifdef SNOOP_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (ooo_req | ppl_req) begin
            state_q     <= CMD;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            src_q       <= win_ppl_d;
            cmd_valid_q <= 1'b1;
            ooo_gnt_q   <= ~win_ppl_d;
            ppl_gnt_q   <= win_ppl_d;
            bus_ready_q <= 1'b0;
          end
        end
        CMD: begin
          state_q     <= SNOOP;
          cmd_valid_q <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
          cnt_q       <= '0;
`endif
        end
        SNOOP: begin
          if (peer_valid) begin
            state_q     <= RESP;
            resp_code_q <= peer_hit ? 2'd1 : 2'd2;
            resp_data_q <= peer_hit ? peer_data : '0;
            ooo_done_q  <= ~src_q;
            ppl_done_q  <= src_q;
          end
`ifdef SNOOP_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_q     <= RESP;
            resp_code_q <= 2'd3;
            resp_data_q <= '0;
            ooo_done_q  <= ~src_q;
            ppl_done_q  <= src_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          state_q     <= IDLE;
          last_src_q  <= src_q;
          addr_q      <= '0;
          cmd_q       <= '0;
          data_q      <= '0;
          src_q       <= 1'b0;
          ooo_gnt_q   <= 1'b0;
          ppl_gnt_q   <= 1'b0;
          ooo_done_q  <= 1'b0;
          ppl_done_q  <= 1'b0;
          resp_code_q <= '0;
          resp_data_q <= '0;
          bus_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_cmd_valid = cmd_valid_q;
  assign bus_cmd_addr  = addr_q;
  assign bus_cmd_cmd   = cmd_q;
  assign bus_cmd_data  = data_q;
  assign bus_cmd_src   = src_q;
  assign ooo_gnt       = ooo_gnt_q;
  assign ppl_gnt       = ppl_gnt_q;
  assign ooo_done      = ooo_done_q;
  assign ppl_done      = ppl_done_q;
  assign resp_code     = resp_code_q;
  assign resp_data     = resp_data_q;
  assign bus_ready     = bus_ready_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter: per-cycle vector table plus multi-cycle sequences.
// A second instance with TIMEOUT_CYCLES=4 shares the stimulus and carries the timeout scenario.
module tb_coherence_bus_arbiter;

  localparam logic [31:0]  OOO_ADDR = 32'h0000_1040;
  localparam logic [31:0]  PPL_ADDR = 32'h0000_2080;
  localparam logic [2:0]   OOO_CMD  = 3'd2;
  localparam logic [2:0]   PPL_CMD  = 3'd5;
  localparam logic [255:0] OOO_DATA = {8{32'hA5A5_0001}};
  localparam logic [255:0] PPL_DATA = {8{32'h5A5A_0002}};
  localparam logic [255:0] OOO_SNP  = {8{32'h0BAD_C0DE}};
  localparam logic [255:0] PPL_SNP  = {8{32'hFEED_0004}};

  // inputs {rst, ooo_req, ppl_req, ooo_sv, ooo_hit, ppl_sv, ppl_hit}
  localparam logic [6:0] NONE      = 7'b0000000;
  localparam logic [6:0] RST       = 7'b1000000;
  localparam logic [6:0] OREQ      = 7'b0100000;
  localparam logic [6:0] BOTH_MISS = 7'b0111010;
  localparam logic [6:0] PREQ_OHIT = 7'b0011100;
  // outputs {bus_ready, cmd_valid, src, ooo_gnt, ppl_gnt, ooo_done, ppl_done}
  localparam logic [6:0] IDL = 7'b1000000;
  localparam logic [6:0] C_O = 7'b0101000;
  localparam logic [6:0] S_O = 7'b0001000;
  localparam logic [6:0] R_O = 7'b0001010;
  localparam logic [6:0] C_P = 7'b0110100;
  localparam logic [6:0] S_P = 7'b0010100;
  localparam logic [6:0] R_P = 7'b0010101;

  typedef struct {
    logic [6:0] iv;
    logic [6:0] eo;
    logic [1:0] ec;
  } vec_t;

  logic clk, rst;
  logic ooo_req, ppl_req;
  logic [31:0] ooo_addr, ppl_addr;
  logic [2:0] ooo_cmd, ppl_cmd;
  logic [255:0] ooo_data, ppl_data;
  logic ooo_snoop_valid, ppl_snoop_valid, ooo_snoop_hit, ppl_snoop_hit;
  logic [255:0] ooo_snoop_data, ppl_snoop_data;

  logic bus_cmd_valid, bus_cmd_src, ooo_gnt, ppl_gnt, ooo_done, ppl_done, bus_ready;
  logic [31:0] bus_cmd_addr;
  logic [2:0] bus_cmd_cmd;
  logic [255:0] bus_cmd_data, resp_data;
  logic [1:0] resp_code;

  logic t_bus_cmd_valid, t_bus_cmd_src, t_ooo_gnt, t_ppl_gnt, t_ooo_done, t_ppl_done, t_bus_ready;
  logic [31:0] t_bus_cmd_addr;
  logic [2:0] t_bus_cmd_cmd;
  logic [255:0] t_bus_cmd_data, t_resp_data;
  logic [1:0] t_resp_code;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  coherence_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .ooo_req(ooo_req), .ppl_req(ppl_req),
    .ooo_addr(ooo_addr), .ppl_addr(ppl_addr),
    .ooo_cmd(ooo_cmd), .ppl_cmd(ppl_cmd),
    .ooo_data(ooo_data), .ppl_data(ppl_data),
    .ooo_snoop_valid(ooo_snoop_valid), .ppl_snoop_valid(ppl_snoop_valid),
    .ooo_snoop_hit(ooo_snoop_hit), .ppl_snoop_hit(ppl_snoop_hit),
    .ooo_snoop_data(ooo_snoop_data), .ppl_snoop_data(ppl_snoop_data),
    .bus_cmd_valid(bus_cmd_valid), .bus_cmd_addr(bus_cmd_addr),
    .bus_cmd_cmd(bus_cmd_cmd), .bus_cmd_data(bus_cmd_data), .bus_cmd_src(bus_cmd_src),
    .ooo_gnt(ooo_gnt), .ppl_gnt(ppl_gnt), .ooo_done(ooo_done), .ppl_done(ppl_done),
    .resp_code(resp_code), .resp_data(resp_data), .bus_ready(bus_ready)
  );

  coherence_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst),
    .ooo_req(ooo_req), .ppl_req(ppl_req),
    .ooo_addr(ooo_addr), .ppl_addr(ppl_addr),
    .ooo_cmd(ooo_cmd), .ppl_cmd(ppl_cmd),
    .ooo_data(ooo_data), .ppl_data(ppl_data),
    .ooo_snoop_valid(ooo_snoop_valid), .ppl_snoop_valid(ppl_snoop_valid),
    .ooo_snoop_hit(ooo_snoop_hit), .ppl_snoop_hit(ppl_snoop_hit),
    .ooo_snoop_data(ooo_snoop_data), .ppl_snoop_data(ppl_snoop_data),
    .bus_cmd_valid(t_bus_cmd_valid), .bus_cmd_addr(t_bus_cmd_addr),
    .bus_cmd_cmd(t_bus_cmd_cmd), .bus_cmd_data(t_bus_cmd_data), .bus_cmd_src(t_bus_cmd_src),
    .ooo_gnt(t_ooo_gnt), .ppl_gnt(t_ppl_gnt), .ooo_done(t_ooo_done), .ppl_done(t_ppl_done),
    .resp_code(t_resp_code), .resp_data(t_resp_data), .bus_ready(t_bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=50000", $time);
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [6:0] eo, input logic [1:0] ec);
    logic busy;
    logic [255:0] exp_rd;
    busy   = ~eo[6];
    exp_rd = (ec == 2'd1) ? (eo[4] ? OOO_SNP : PPL_SNP) : 256'h0;
    cmp({tag, ".bus_ready"},     256'(bus_ready),     256'(eo[6]));
    cmp({tag, ".bus_cmd_valid"}, 256'(bus_cmd_valid), 256'(eo[5]));
    cmp({tag, ".bus_cmd_src"},   256'(bus_cmd_src),   256'(eo[4]));
    cmp({tag, ".ooo_gnt"},       256'(ooo_gnt),       256'(eo[3]));
    cmp({tag, ".ppl_gnt"},       256'(ppl_gnt),       256'(eo[2]));
    cmp({tag, ".ooo_done"},      256'(ooo_done),      256'(eo[1]));
    cmp({tag, ".ppl_done"},      256'(ppl_done),      256'(eo[0]));
    cmp({tag, ".resp_code"},     256'(resp_code),     256'(ec));
    cmp({tag, ".resp_data"},     resp_data,           exp_rd);
    cmp({tag, ".bus_cmd_addr"},  256'(bus_cmd_addr),
        busy ? 256'(eo[4] ? PPL_ADDR : OOO_ADDR) : 256'h0);
    cmp({tag, ".bus_cmd_cmd"},   256'(bus_cmd_cmd),
        busy ? 256'(eo[4] ? PPL_CMD : OOO_CMD) : 256'h0);
    cmp({tag, ".bus_cmd_data"},  bus_cmd_data,
        busy ? (eo[4] ? PPL_DATA : OOO_DATA) : 256'h0);
  endtask

  task automatic check_to(input string tag, input logic e_rdy, input logic e_gnt,
                          input logic e_done, input logic [1:0] e_code);
    cmp({tag, ".t_bus_ready"}, 256'(t_bus_ready), 256'(e_rdy));
    cmp({tag, ".t_ooo_gnt"},   256'(t_ooo_gnt),   256'(e_gnt));
    cmp({tag, ".t_ooo_done"},  256'(t_ooo_done),  256'(e_done));
    cmp({tag, ".t_resp_code"}, 256'(t_resp_code), 256'(e_code));
    cmp({tag, ".t_resp_data"}, t_resp_data,       256'h0);
  endtask

  task automatic drive(input logic [6:0] iv);
    {rst, ooo_req, ppl_req, ooo_snoop_valid, ooo_snoop_hit, ppl_snoop_valid, ppl_snoop_hit} = iv;
  endtask

  task automatic step(input logic [6:0] iv, input string tag, input logic [6:0] eo, input logic [1:0] ec);
    drive(iv);
    @(posedge clk);
    #1;
    check_outs(tag, eo, ec);
  endtask

  initial begin
    drive(RST);
    ooo_addr = OOO_ADDR; ppl_addr = PPL_ADDR;
    ooo_cmd  = OOO_CMD;  ppl_cmd  = PPL_CMD;
    ooo_data = OOO_DATA; ppl_data = PPL_DATA;
    ooo_snoop_data = OOO_SNP; ppl_snoop_data = PPL_SNP;

    // reset state, lone ooo request with a hit in the first SNOOP cycle
    tbl.push_back('{RST,        IDL, 2'd0});
    tbl.push_back('{7'b1100000, IDL, 2'd0});
    tbl.push_back('{OREQ,       C_O, 2'd0});
    tbl.push_back('{NONE,       S_O, 2'd0});
    tbl.push_back('{7'b0000011, R_O, 2'd1});
    tbl.push_back('{NONE,       IDL, 2'd0});
    // both requesting continuously after reset: ooo, ppl, ooo, ppl
    tbl.push_back('{RST,        IDL, 2'd0});
    for (int k = 0; k < 2; k++) begin
      tbl.push_back('{BOTH_MISS, C_O, 2'd0});
      tbl.push_back('{BOTH_MISS, S_O, 2'd0});
      tbl.push_back('{BOTH_MISS, R_O, 2'd2});
      tbl.push_back('{BOTH_MISS, IDL, 2'd0});
      tbl.push_back('{BOTH_MISS, C_P, 2'd0});
      tbl.push_back('{BOTH_MISS, S_P, 2'd0});
      tbl.push_back('{BOTH_MISS, R_P, 2'd2});
      tbl.push_back('{BOTH_MISS, IDL, 2'd0});
    end
    // lone held ppl request re-granted back to back
    for (int k = 0; k < 2; k++) begin
      tbl.push_back('{PREQ_OHIT, C_P, 2'd0});
      tbl.push_back('{PREQ_OHIT, S_P, 2'd0});
      tbl.push_back('{PREQ_OHIT, R_P, 2'd1});
      tbl.push_back('{PREQ_OHIT, IDL, 2'd0});
    end

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].iv, $sformatf("vec%0d", i), tbl[i].eo, tbl[i].ec);

    // ppl-owned: own snoop pulse ignored, ooo reply arrives 5 cycles after SNOOP entry
    step(7'b0010000, "delay_cmd", C_P, 2'd0);
    ppl_addr = 32'hDEAD_BEEF;
    ppl_data = '1;
    step(7'b0001100, "delay_snp0", S_P, 2'd0);
    step(7'b0000011, "delay_snp1", S_P, 2'd0);
    for (int k = 0; k < 3; k++)
      step(7'b0000100, $sformatf("delay_snp%0d", k + 2), S_P, 2'd0);
    step(7'b0001100, "delay_resp", R_P, 2'd1);
    step(NONE, "delay_idle", IDL, 2'd0);
    ppl_addr = PPL_ADDR;
    ppl_data = PPL_DATA;

    // completed ooo miss so that ooo was served last
    step(OREQ,       "miss_cmd",  C_O, 2'd0);
    step(NONE,       "miss_snp",  S_O, 2'd0);
    step(7'b0000010, "miss_resp", R_O, 2'd2);
    step(NONE,       "miss_idle", IDL, 2'd0);

    // reset during SNOOP aborts without done; next contention goes to ooo
    step(OREQ,       "abort_cmd", C_O, 2'd0);
    step(NONE,       "abort_snp", S_O, 2'd0);
    step(7'b1000011, "abort_rst", IDL, 2'd0);
    step(RST,        "abort_rst_hold", IDL, 2'd0);
    step(7'b0110000, "post_rst_grant", C_O, 2'd0);

    // no snoop reply at all
    step(NONE, "to_snp0", S_O, 2'd0);
    check_to("to_snp0", 1'b0, 1'b1, 1'b0, 2'd0);
`ifdef SNOOP_TIMEOUT_EN
    for (int k = 1; k < 4; k++) begin
      step(NONE, $sformatf("to_snp%0d", k), S_O, 2'd0);
      check_to($sformatf("to_snp%0d", k), 1'b0, 1'b1, 1'b0, 2'd0);
    end
    step(NONE, "to_resp", S_O, 2'd0);
    check_to("to_resp", 1'b0, 1'b1, 1'b1, 2'd3);
    step(NONE, "to_idle", S_O, 2'd0);
    check_to("to_idle", 1'b1, 1'b0, 1'b0, 2'd0);
`else
    for (int k = 0; k < 100; k++) @(posedge clk);
    #1;
    check_outs("stuck_snoop", S_O, 2'd0);
    check_to("stuck_snoop", 1'b0, 1'b1, 1'b0, 2'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coherence_bus_arbiter.md
COHERENCE_BUS_ARBITER -- requirements
Module: coherence_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of SNOOP-state cycles before timeout (used only with SNOOP_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports ooo_req / ppl_req  in  1  each  bus transaction request per requester.
REQ-005 SHALL have ports ooo_addr / ppl_addr  in  32, ooo_cmd / ppl_cmd  in  3, ooo_data / ppl_data  in  256  request payloads.
REQ-006 SHALL have ports ooo_snoop_valid / ppl_snoop_valid  in  1, ooo_snoop_hit / ppl_snoop_hit  in  1, ooo_snoop_data / ppl_snoop_data  in  256  snoop replies from each cache.
REQ-007 SHALL have ports bus_cmd_valid out 1, bus_cmd_addr out 32, bus_cmd_cmd out 3, bus_cmd_data out 256, bus_cmd_src out 1 (0 = ooo, 1 = ppl)  broadcast command.
REQ-008 SHALL have ports ooo_gnt / ppl_gnt  out  1  ownership indication.
REQ-009 SHALL have ports ooo_done / ppl_done  out  1  single-cycle completion pulses.
REQ-010 SHALL have ports resp_code out 2 (0 none, 1 hit, 2 miss, 3 timeout), resp_data out 256, bus_ready out 1.

Function
REQ-011 SHALL implement the states IDLE, CMD, SNOOP and RESP; the transitions are IDLE->CMD on any sampled req, CMD->SNOOP unconditionally, SNOOP->RESP on the peer's snoop_valid (or on timeout), and RESP->IDLE unconditionally.
REQ-012 SHALL assert bus_ready only in IDLE, and SHALL sample requests only in IDLE.
REQ-013 SHALL arbitrate round-robin: a lone requester wins; when both request, the winner is the requester other than last_src. last_src updates on the RESP cycle.
REQ-014 SHALL latch the winner's addr, cmd, data and id on the IDLE->CMD edge; requester inputs are don't-care after the grant.
REQ-015 SHALL drive bus_cmd_addr, bus_cmd_cmd, bus_cmd_data and bus_cmd_src from the latches in CMD, SNOOP and RESP, and SHALL drive them to zero in IDLE; bus_cmd_valid is high in CMD only.
REQ-016 SHALL hold the owner's gnt high in CMD, SNOOP and RESP; both gnt signals are low in IDLE, and both are never high together.
REQ-017 SHALL sample snoop_valid only from the non-owner cache and only in SNOOP; the owner's own snoop_valid is ignored, and snoop_valid asserted during CMD is ignored.
REQ-018 SHALL capture the peer's snoop_hit and snoop_data when its snoop_valid is high in SNOOP; in RESP, resp_code = 1 for a hit and 2 for a miss, and resp_data = the captured data on a hit and zero on a miss.
REQ-019 SHALL pulse the owner's done for exactly the RESP cycle; resp_code and resp_data are zero outside RESP.
REQ-020 SHALL have a minimum latency of req in cycle N (IDLE) -> CMD at N+1 -> SNOOP at N+2 -> RESP/done at N+3 (when snoop_valid is high at N+2) -> IDLE at N+4.
REQ-021 SHALL, when the just-served requester still holds req in the IDLE cycle after RESP and the other is also requesting, grant the other; a lone held req is re-granted back-to-back.

Reset
REQ-022 SHALL, on rst, force state = IDLE and last_src = 1 (so ooo wins the first contention), and clear all latches and the timeout counter.
REQ-023 SHALL, during rst, drive every output to 0 except bus_ready; bus_ready is 1 from the first cycle after rst deasserts.
REQ-024 SHALL, when rst arrives mid-transaction, abort the transaction with no done pulse.

Configuration
REQ-025 SHALL, with SNOOP_TIMEOUT_EN defined, count SNOOP cycles (the counter clears on SNOOP entry) and go to RESP with resp_code 3 and resp_data 0 once TIMEOUT_CYCLES cycles elapse without a peer snoop_valid; snoop_valid and timeout in the same cycle resolve as a valid reply.
REQ-026 SHALL, without SNOOP_TIMEOUT_EN, wait in SNOOP indefinitely, never produce resp_code 3, ignore TIMEOUT_CYCLES, and include no counter logic.

Verification
REQ-027 SHALL cover a lone ooo_req with addr 0x0000_1040 and ppl_snoop_valid/hit = 1 in the first SNOOP cycle, requiring bus_cmd_valid at N+1, ooo_done at N+3, resp_code = 1 and resp_data = the ppl data.
REQ-028 SHALL cover ooo_req and ppl_req held together for 4 transactions after reset, requiring the grants ooo, ppl, ooo, ppl.
REQ-029 SHALL cover a ppl-owned transaction with ppl_snoop_valid pulsed and ooo_snoop_valid/hit = 0/1 delayed 5 cycles, requiring the ppl_snoop_valid pulse to be ignored, RESP 5 cycles after SNOOP entry, and resp_code = 1.
REQ-030 SHALL cover, with SNOOP_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no snoop reply, requiring resp_code = 3 with done after 4 SNOOP cycles; without the macro, the bench requires the arbiter to remain in SNOOP after 100 cycles.
REQ-031 SHALL cover rst asserted while in SNOOP, requiring no done pulse, all outputs = 0 except bus_ready, and the next contention granted to ooo.
